// File: rtl/rv_hazard_pkg.sv
// rtl/rv_hazard_pkg.sv - shared encodings for the RV32I hazard/scoreboard unit
//
// Purpose: writeback-source and forwarding-select encodings plus the
// redirect-flush FSM state type, shared by the hazard unit and its users.
package rv_hazard_pkg;

  // EX writeback source that marks a load
  localparam logic [2:0] WB_SRC_MEM = 3'b001;

  // Operand-select encodings for the EX stage forwarding muxes
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// rtl/hazard_scoreboard_ctrl_if.sv - pipeline-to-hazard-unit signal bundle
//
// Purpose: groups the decode/EX/MEM/WB/long-unit observations and the
// stall/flush/forward controls exchanged between the core and the hazard unit.
// Modports: master = core pipeline (drives i_*, receives o_*),
//           slave  = hazard unit  (receives i_*, drives o_*).
interface hazard_scoreboard_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int PERF_W = 16
);
  logic [ADDR_W-1:0] i_id_src_0;
  logic [ADDR_W-1:0] i_id_src_1;
  logic              i_id_use_0;
  logic              i_id_use_1;
  logic [ADDR_W-1:0] i_id_dst;
  logic              i_id_we;
  logic              i_id_long;
  logic [ADDR_W-1:0] i_ie_src_0;
  logic [ADDR_W-1:0] i_ie_src_1;
  logic [ADDR_W-1:0] i_ie_dst;
  logic [2:0]        i_ie_wb_src;
  logic              i_ie_long_issue;
  logic              i_ie_nxt_pc_src;
  logic [ADDR_W-1:0] i_im_dst;
  logic              i_im_we;
  logic [ADDR_W-1:0] i_iwb_dst;
  logic              i_iwb_we;
  logic              i_lu_done;
  logic [ADDR_W-1:0] i_lu_dst;

  logic              o_if_stall;
  logic              o_id_stall;
  logic              o_id_flush;
  logic              o_ie_flush;
  logic [1:0]        o_ie_forward_0;
  logic [1:0]        o_ie_forward_1;
  logic              o_sb_busy;
  logic [PERF_W-1:0] o_stall_cycles;

  modport master (
    output i_id_src_0, i_id_src_1, i_id_use_0, i_id_use_1, i_id_dst, i_id_we,
           i_id_long, i_ie_src_0, i_ie_src_1, i_ie_dst, i_ie_wb_src,
           i_ie_long_issue, i_ie_nxt_pc_src, i_im_dst, i_im_we, i_iwb_dst,
           i_iwb_we, i_lu_done, i_lu_dst,
    input  o_if_stall, o_id_stall, o_id_flush, o_ie_flush, o_ie_forward_0,
           o_ie_forward_1, o_sb_busy, o_stall_cycles
  );

  modport slave (
    input  i_id_src_0, i_id_src_1, i_id_use_0, i_id_use_1, i_id_dst, i_id_we,
           i_id_long, i_ie_src_0, i_ie_src_1, i_ie_dst, i_ie_wb_src,
           i_ie_long_issue, i_ie_nxt_pc_src, i_im_dst, i_im_we, i_iwb_dst,
           i_iwb_we, i_lu_done, i_lu_dst,
    output o_if_stall, o_id_stall, o_id_flush, o_ie_flush, o_ie_forward_0,
           o_ie_forward_1, o_sb_busy, o_stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-register bitmap and in-flight long-op count
//
// Purpose: one pending bit per architectural register for results owed by the
// long unit, plus a count of long operations in flight.
// Ports: i_clk/i_rst; i_issue/i_issue_dst set a bit; i_done/i_done_dst clear
// a bit; i_rd_addr_0..2 -> o_pend_0..2 lookups; o_busy = any bit set;
// o_cnt = long ops in flight.
module hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int MAX_LONG = 2,
  localparam int CNT_W   = $clog2(MAX_LONG + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_issue,
  input  logic [ADDR_W-1:0] i_issue_dst,
  input  logic              i_done,
  input  logic [ADDR_W-1:0] i_done_dst,
  input  logic [ADDR_W-1:0] i_rd_addr_0,
  input  logic [ADDR_W-1:0] i_rd_addr_1,
  input  logic [ADDR_W-1:0] i_rd_addr_2,
  output logic              o_pend_0,
  output logic              o_pend_1,
  output logic              o_pend_2,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  // x0 never has a pending write, so it carries no storage
  logic [NREG-1:1] sb_q;
  logic [NREG-1:0] sb_all;
  logic [CNT_W-1:0] cnt_q;

  assign sb_all = {sb_q, 1'b0};

  // A set and a clear hitting the same register resolve to set: the new
  // issue owns the register after the old result retires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sb_q <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (i_issue && (i_issue_dst == ADDR_W'(i))) begin
          sb_q[i] <= 1'b1;
        end else if (i_done && (i_done_dst == ADDR_W'(i))) begin
          sb_q[i] <= 1'b0;
        end
      end
    end
  end

  // Saturating at both ends so a protocol slip cannot wrap the count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_issue && !i_done && (cnt_q != CNT_W'(MAX_LONG))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!i_issue && i_done && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign o_pend_0 = sb_all[i_rd_addr_0];
  assign o_pend_1 = sb_all[i_rd_addr_1];
  assign o_pend_2 = sb_all[i_rd_addr_2];
  assign o_busy   = |sb_q;
  assign o_cnt    = cnt_q;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - RV32I hazard unit: forwarding, stalls, flushes
//
// Purpose: combinational forwarding and load-use detection, scoreboard and
// capacity stalls for long operations, a multi-cycle redirect flush and a
// saturating stall-cycle counter.
// Ports: i_clk, i_rst (async, active-high); hz_if (slave modport) carries
// decode/EX/MEM/WB/long-unit inputs and stall/flush/forward/perf outputs.
module hazard_scoreboard_ctrl
  import rv_hazard_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int MAX_LONG     = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  hazard_scoreboard_ctrl_if.slave  hz_if
);

  localparam int CNT_W = $clog2(MAX_LONG + 1);
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic             pend_0, pend_1, pend_2;
  logic [CNT_W-1:0] cnt;
  logic             lu_hz, sb_hz, cap_hz, hz, redir, stall;

  flush_state_t     state_q, state_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [PERF_W-1:0] stall_cycles_q;

  hazard_scoreboard #(
    .ADDR_W   (ADDR_W),
    .MAX_LONG (MAX_LONG)
  ) u_sb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_issue     (hz_if.i_ie_long_issue),
    .i_issue_dst (hz_if.i_ie_dst),
    .i_done      (hz_if.i_lu_done),
    .i_done_dst  (hz_if.i_lu_dst),
    .i_rd_addr_0 (hz_if.i_id_src_0),
    .i_rd_addr_1 (hz_if.i_id_src_1),
    .i_rd_addr_2 (hz_if.i_id_dst),
    .o_pend_0    (pend_0),
    .o_pend_1    (pend_1),
    .o_pend_2    (pend_2),
    .o_busy      (hz_if.o_sb_busy),
    .o_cnt       (cnt)
  );

  // MEM holds the younger result, so it is checked before WB
  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src,
                                         input logic [ADDR_W-1:0] m_dst,
                                         input logic              m_we,
                                         input logic [ADDR_W-1:0] w_dst,
                                         input logic              w_we);
    if (m_we && (src == m_dst) && (src != '0)) return FWD_MEM;
    if (w_we && (src == w_dst) && (src != '0)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign hz_if.o_ie_forward_0 = fwd_sel(hz_if.i_ie_src_0, hz_if.i_im_dst,
                                        hz_if.i_im_we, hz_if.i_iwb_dst,
                                        hz_if.i_iwb_we);
  assign hz_if.o_ie_forward_1 = fwd_sel(hz_if.i_ie_src_1, hz_if.i_im_dst,
                                        hz_if.i_im_we, hz_if.i_iwb_dst,
                                        hz_if.i_iwb_we);

  assign lu_hz = (hz_if.i_ie_wb_src == WB_SRC_MEM) && (hz_if.i_ie_dst != '0) &&
                 ((hz_if.i_id_use_0 && (hz_if.i_id_src_0 == hz_if.i_ie_dst)) ||
                  (hz_if.i_id_use_1 && (hz_if.i_id_src_1 == hz_if.i_ie_dst)));

  // Third lookup catches WAW against a still-pending long result
  assign sb_hz = (hz_if.i_id_use_0 && pend_0) ||
                 (hz_if.i_id_use_1 && pend_1) ||
                 (hz_if.i_id_we    && pend_2);

  // An issue this cycle already consumes a slot the decoded op would need
  assign cap_hz = hz_if.i_id_long &&
                  (({1'b0, cnt} + (CNT_W+1)'(hz_if.i_ie_long_issue)) >=
                   (CNT_W+1)'(MAX_LONG));

  assign hz = lu_hz | sb_hz | cap_hz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  // fc counts the flush cycles still owed after the current one
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    case (state_q)
      RUN: begin
        if (hz_if.i_ie_nxt_pc_src && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          fc_d    = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (hz_if.i_ie_nxt_pc_src) begin
          fc_d = FC_W'(FLUSH_CYCLES - 1);
        end else if (fc_q <= FC_W'(1)) begin
          state_d = RUN;
          fc_d    = '0;
        end else begin
          fc_d = fc_q - FC_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        fc_d    = '0;
      end
    endcase
  end

  assign redir = hz_if.i_ie_nxt_pc_src | (state_q == FLUSH);

  // Instructions behind a redirect are wrong-path, so flushing wins over stalling
  assign stall = hz & ~redir;

  assign hz_if.o_id_flush = redir;
  assign hz_if.o_ie_flush = redir | hz;
  assign hz_if.o_if_stall = stall;
  assign hz_if.o_id_stall = stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + PERF_W'(1);
    end
  end

  assign hz_if.o_stall_cycles = stall_cycles_q;

endmodule
